// File: rtl/exc_ctrl.sv
// Prioritised multi-source exception controller with a private CP0 register file.
// Picks the oldest eligible stage, flushes, vectors to the handler and returns via ERET.
module exc_ctrl #(
    parameter int                N_SRC        = 4,
    parameter int                DATA_W       = 32,
    parameter logic [DATA_W-1:0] HANDLER_ADDR = 32'h0000_0080
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC-1:0]        exc_req,
    input  logic [5*N_SRC-1:0]      exc_code,
    input  logic [DATA_W*N_SRC-1:0] exc_pc,
    input  logic [DATA_W-1:0]       exc_badaddr,
    input  logic                    eret,
    input  logic                    cp0_we,
    input  logic [4:0]              cp0_addr,
    input  logic [DATA_W-1:0]       cp0_wdata,
    output logic [DATA_W-1:0]       cp0_rdata,
    output logic [N_SRC-1:0]        flush,
    output logic                    wb_disable,
    output logic                    redirect_valid,
    output logic [DATA_W-1:0]       redirect_pc,
    output logic                    exc_active
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        HANDLER = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_ie;
    logic               r_exl;
    logic [N_SRC-1:0]   r_im;
    logic [4:0]         r_excCode;
    logic [N_SRC-1:0]   r_ip;
    logic               r_lost;
    logic [DATA_W-1:0]  r_epc;
    logic [DATA_W-1:0]  r_badVAddr;
    logic [15:0]        r_excCount;

    logic [N_SRC-1:0]   w_elig;
    logic               w_anyElig;
    logic [IDX_W-1:0]   w_winner;
    logic [4:0]         w_winCode;
    logic [DATA_W-1:0]  w_winPc;
    logic [N_SRC-1:0]   w_flushAcc;
    logic               w_accept;
    logic               w_eretTaken;
    logic [DATA_W-1:0]  w_status;
    logic [DATA_W-1:0]  w_cause;

    assign w_elig = exc_req & r_im;

    // Later (older) stages overwrite earlier ones, so the highest index wins.
    always_comb begin
        w_anyElig = 1'b0;
        w_winner  = '0;
        w_winCode = '0;
        w_winPc   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_elig[i]) begin
                w_anyElig = 1'b1;
                w_winner  = i[IDX_W-1:0];
                w_winCode = exc_code[5*i +: 5];
                w_winPc   = exc_pc[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        w_flushAcc = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_flushAcc[i] = (i[IDX_W-1:0] <= w_winner);
        end
    end

    assign w_accept    = rst_n && (r_state == IDLE) && r_ie && !r_exl && w_anyElig;
    assign w_eretTaken = rst_n && (r_state == HANDLER) && eret;

    always_comb begin
        w_status            = '0;
        w_status[0]         = r_ie;
        w_status[1]         = r_exl;
        w_status[8 +: N_SRC] = r_im;
    end

    always_comb begin
        w_cause              = '0;
        w_cause[6:2]         = r_excCode;
        w_cause[8 +: N_SRC]  = r_ip;
        w_cause[DATA_W-1]    = r_lost;
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            ADDR_BADVADDR: cp0_rdata = r_badVAddr;
            ADDR_COUNT:    cp0_rdata = {{(DATA_W-16){1'b0}}, r_excCount};
            ADDR_STATUS:   cp0_rdata = w_status;
            ADDR_CAUSE:    cp0_rdata = w_cause;
            ADDR_EPC:      cp0_rdata = r_epc;
            default:       cp0_rdata = '0;
        endcase
    end

    // Control outputs are decoded from state plus same-cycle request/eret; reset forces them low.
    always_comb begin
        flush          = '0;
        wb_disable     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (rst_n) begin
            if (w_accept) begin
                flush      = w_flushAcc;
                wb_disable = 1'b1;
            end else if (r_state == TAKE) begin
                flush          = '1;
                redirect_valid = 1'b1;
                redirect_pc    = HANDLER_ADDR;
            end else if (w_eretTaken) begin
                flush[0]       = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = r_epc;
            end
        end
    end

    assign exc_active = r_exl;

    // Software writes come first so that exception capture and the FSM override them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ie       <= 1'b1;
            r_exl      <= 1'b0;
            r_im       <= '1;
            r_excCode  <= '0;
            r_ip       <= '0;
            r_lost     <= 1'b0;
            r_epc      <= '0;
            r_badVAddr <= '0;
            r_excCount <= '0;
        end else begin
            r_ip <= exc_req;

            if (cp0_we && !w_accept) begin
                case (cp0_addr)
                    ADDR_STATUS: begin
                        r_ie  <= cp0_wdata[0];
                        r_exl <= cp0_wdata[1];
                        r_im  <= cp0_wdata[8 +: N_SRC];
                        if ((r_state == HANDLER) && !cp0_wdata[1]) begin
                            r_state <= IDLE;
                        end
                    end
                    ADDR_CAUSE: begin
                        if (!cp0_wdata[DATA_W-1]) begin
                            r_lost <= 1'b0;
                        end
                    end
                    ADDR_EPC: r_epc <= cp0_wdata;
                    default: ;
                endcase
            end

            if (r_exl && w_anyElig) begin
                r_lost <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_epc     <= w_winPc;
                        r_excCode <= w_winCode;
                        r_exl     <= 1'b1;
                        if (r_excCount != 16'hFFFF) begin
                            r_excCount <= r_excCount + 16'd1;
                        end
                        if ((w_winCode == 5'd4) || (w_winCode == 5'd5)) begin
                            r_badVAddr <= exc_badaddr;
                        end
                        r_state <= TAKE;
                    end
                end
                TAKE: r_state <= HANDLER;
                HANDLER: begin
                    if (eret || !r_exl) begin
                        r_exl   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Parametrised exception controller with its own CP0 register file. It replaces the fixed divide-by-zero / store-address pair of detectors with N_SRC prioritised per-stage exception sources. It captures EPC, Cause and BadVAddr, generates per-stage flushes and a PC redirect to the handler, and returns to EPC on ERET. It sits beside the hazard unit, takes requests from the D/E/M/W stages, and drives the pipeline-register flush inputs and the fetch-PC mux.

Parameters:
N_SRC, 4, number of exception sources = pipeline stages; index 0 = youngest (D), N_SRC-1 = oldest (W)
DATA_W, 32, data/PC width
HANDLER_ADDR, 32'h0000_0080, exception vector

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
exc_req  input  N_SRC  per-stage exception request, level, sampled every cycle
exc_code  input  5*N_SRC  ExcCode of each source (slice i = [5i+4:5i])
exc_pc  input  DATA_W*N_SRC  PC of the faulting instruction in each stage
exc_badaddr  input  DATA_W  faulting memory address (E/M stage ALU result)
eret  input  1  ERET in D, single-cycle pulse
cp0_we  input  1  MTC0 write strobe
cp0_addr  input  5  CP0 register index (rd)
cp0_wdata  input  DATA_W  MTC0 data
cp0_rdata  output  DATA_W  MFC0 data, combinational
flush  output  N_SRC  per-stage flush, bit i clears pipeline register of stage i
wb_disable  output  1  suppress register-file/memory write this cycle
redirect_valid  output  1  override fetch PC this cycle
redirect_pc  output  DATA_W  redirect target
exc_active  output  1  Status.EXL mirror (in handler)

Behaviour:
- CP0 map: 8 BadVAddr (RO), 9 ExcCount (RO, 16-bit saturating, zero-extended), 12 Status, 13 Cause, 14 EPC (RW). Other addresses read 0; writes to them are ignored.
- Status: bit0 IE, bit1 EXL, bits[8+N_SRC-1:8] IM (per-source enable); all other bits read 0. Cause: [6:2] ExcCode, [8+N_SRC-1:8] IP (raw exc_req snapshot, updated every cycle), bit31 LOST (sticky). Writing Cause clears LOST only when wdata[31]=0; no other Cause bit is writable.
- Reset values: Status = IE=1, EXL=0, IM=all 1s; Cause, EPC, BadVAddr, ExcCount = 0; state IDLE. All outputs are 0 in reset except cp0_rdata, which follows cp0_addr.
- Eligible source i: exc_req[i] & IM[i]. Accept = IE & !EXL & any eligible. Winner = highest eligible index (oldest instruction first).
- FSM IDLE / TAKE / HANDLER:
  IDLE, on accept (cycle T, combinational): flush[w:0]=1, wb_disable=1. At the edge: EPC<=exc_pc[w], ExcCode<=exc_code[w], EXL<=1, ExcCount+=1 (saturating at 0xFFFF). BadVAddr<=exc_badaddr only when the code is 4 (AdEL) or 5 (AdES). Next state TAKE.
  TAKE (T+1): redirect_valid=1, redirect_pc=HANDLER_ADDR, flush=all 1s. Next state HANDLER.
  HANDLER: exc_active=1. Any eligible request while EXL=1 sets LOST and is otherwise dropped. On eret: redirect_valid=1, redirect_pc=EPC, flush[0]=1. At the edge EXL<=0 and next state is IDLE.
- Latency: flush is 0 cycles after request; the handler redirect is exactly 1 cycle after; the ERET redirect is 0 cycles after.
- eret outside HANDLER is ignored.
- MTC0 in the same cycle as accept is dropped entirely; exception capture wins.
- A software write that sets EXL in IDLE blocks acceptance but does not change state. A write clearing EXL in HANDLER moves the FSM to IDLE at that edge without a redirect.
- Simultaneous eret and an eligible request in HANDLER: eret is taken, LOST is set, and the request is re-evaluated in IDLE next cycle if still asserted.
- rst_n low at any time, including mid-TAKE/HANDLER, returns to IDLE immediately and drops all outputs.

Test Plan:
- Reset, then exc_req=4'b0010, code[1]=12, pc[1]=0x40. Required: cycle T flush=4'b0011, wb_disable=1. T+1 redirect_valid=1, redirect_pc=0x80, flush=4'b1111. Then EPC=0x40, Cause[6:2]=12, Status=0x0F03.
- exc_req=4'b0101 with code[2]=5, badaddr=0x900 -> winner 2, flush=4'b0111, BadVAddr=0x900, ExcCount=1.
- In HANDLER, exc_req=4'b0001 -> no flush, Cause bit31=1. Then eret -> redirect_pc=EPC, exc_active=0 next cycle. MTC0 Cause=0 -> LOST cleared.
- MTC0 Status=0x0000_0101 (IM[0] only), then exc_req=4'b0010 -> ignored. Then exc_req=4'b0001 -> accepted. MTC0 with IE=0 -> no request accepted.
- Accept and cp0_we to EPC=0x1234 in the same cycle -> EPC holds exc_pc[w], not 0x1234. eret in IDLE -> redirect_valid stays 0.
- Drive rst_n low during TAKE -> redirect_valid and flush go to 0 immediately. After release: Status=0x0000_0F01, state IDLE.
